// File: rtl/wash_countdown.sv
// rtl/wash_countdown.sv - preset 3-digit BCD countdown timer with multiplexed 7-segment display
//
// Parameters:
//   TICK_CYCLES  clk cycles per one-count decrement
//   SCAN_BITS    width of the free-running scan divider; its top 2 bits pick the digit
// Ports:
//   clk          single clock, all state changes on its rising edge
//   rst_n        asynchronous active-low reset
//   load         one-cycle request to capture d1/d2/d3/sign (ignored in RUN/PAUSE or if any digit > 9)
//   d1, d2, d3   preset ones / tens / hundreds digit, BCD
//   sign         preset sign flag, display-only, shown as '-' on digit 3
//   start        begin or resume the countdown
//   pause        suspend the countdown (wins over start)
//   light        segments, bit0=a .. bit6=g, bit7=dp, active-high
//   ena          one-hot digit enable: [0]=ones [1]=tens [2]=hundreds [3]=sign
//   busy         high in RUN and PAUSE
//   done         high in DONE
module wash_countdown #(
    parameter int TICK_CYCLES = 100000000,
    parameter int SCAN_BITS   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic       sign,
    input  logic       start,
    input  logic       pause,
    output logic [7:0] light,
    output logic [3:0] ena,
    output logic       busy,
    output logic       done
);

    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TICK_W-1:0]    TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    localparam logic [TICK_W-1:0]    TICK_ONE  = TICK_W'(1);
    localparam logic [SCAN_BITS-1:0] SCAN_ONE  = SCAN_BITS'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOADED = 3'd1,
        S_RUN    = 3'd2,
        S_PAUSE  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                r_state;
    logic [3:0]            r_ones;
    logic [3:0]            r_tens;
    logic [3:0]            r_hund;
    logic                  r_sign;
    logic [TICK_W-1:0]     r_tick;
    logic [SCAN_BITS-1:0]  r_scan;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_load_ok;
    logic                  w_cnt_zero;
    logic                  w_cnt_one;
    logic                  w_tick_wrap;
    logic [3:0]            w_dec_ones;
    logic [3:0]            w_dec_tens;
    logic [3:0]            w_dec_hund;
    logic [1:0]            w_sel;

    // A preset is only accepted when every digit is a legal BCD value.
    assign w_load_ok   = load && (d1 <= 4'd9) && (d2 <= 4'd9) && (d3 <= 4'd9);
    assign w_cnt_zero  = (r_hund == 4'd0) && (r_tens == 4'd0) && (r_ones == 4'd0);
    assign w_cnt_one   = (r_hund == 4'd0) && (r_tens == 4'd0) && (r_ones == 4'd1);
    assign w_tick_wrap = (r_tick == TICK_LAST);

    // BCD decrement with borrow. A zero count is never decremented by the
    // FSM, but it is held at 000 here so the digits can never leave 0..9.
    always_comb begin
        w_dec_ones = r_ones;
        w_dec_tens = r_tens;
        w_dec_hund = r_hund;
        if (!w_cnt_zero) begin
            if (r_ones != 4'd0) begin
                w_dec_ones = r_ones - 4'd1;
            end else begin
                w_dec_ones = 4'd9;
                if (r_tens != 4'd0) begin
                    w_dec_tens = r_tens - 4'd1;
                end else begin
                    w_dec_tens = 4'd9;
                    w_dec_hund = r_hund - 4'd1;
                end
            end
        end
    end

    // Control FSM; busy/done are registered alongside the state they mirror.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ones  <= 4'd0;
            r_tens  <= 4'd0;
            r_hund  <= 4'd0;
            r_sign  <= 1'b0;
            r_tick  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_LOADED, S_DONE: begin
                    // A valid load takes priority over start in LOADED.
                    if (w_load_ok) begin
                        r_ones  <= d1;
                        r_tens  <= d2;
                        r_hund  <= d3;
                        r_sign  <= sign;
                        r_state <= S_LOADED;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else if ((r_state == S_LOADED) && start) begin
                        r_tick <= '0;
                        if (w_cnt_zero) begin
                            // Nothing to count: skip RUN entirely.
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    if (pause) begin
                        // Tick is frozen so a resume continues mid-period.
                        r_state <= S_PAUSE;
                    end else if (w_tick_wrap) begin
                        r_tick <= '0;
                        r_ones <= w_dec_ones;
                        r_tens <= w_dec_tens;
                        r_hund <= w_dec_hund;
                        if (w_cnt_one || w_cnt_zero) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_tick <= r_tick + TICK_ONE;
                    end
                end

                S_PAUSE: begin
                    if (start && !pause) begin
                        r_state <= S_RUN;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Display scan divider: free-running in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan <= '0;
        end else begin
            r_scan <= r_scan + SCAN_ONE;
        end
    end

    assign w_sel = r_scan[SCAN_BITS-1 -: 2];

    function automatic logic [7:0] seg7(input logic [3:0] digit);
        logic [7:0] code;
        case (digit)
            4'd0:    code = 8'h3F;
            4'd1:    code = 8'h06;
            4'd2:    code = 8'h5B;
            4'd3:    code = 8'h4F;
            4'd4:    code = 8'h66;
            4'd5:    code = 8'h6D;
            4'd6:    code = 8'h7D;
            4'd7:    code = 8'h07;
            4'd8:    code = 8'h7F;
            4'd9:    code = 8'h6F;
            default: code = 8'h00;
        endcase
        return code;
    endfunction

    always_comb begin
        light = 8'h00;
        ena   = 4'b0000;
        case (w_sel)
            2'd0: begin
                ena   = 4'b0001;
                light = seg7(r_ones);
            end
            2'd1: begin
                ena   = 4'b0010;
                light = seg7(r_tens);
            end
            2'd2: begin
                ena   = 4'b0100;
                light = seg7(r_hund);
            end
            default: begin
                ena   = 4'b1000;
                light = r_sign ? 8'h40 : 8'h00;
            end
        endcase
    end

    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_wash_countdown.sv
// tb/tb_wash_countdown.sv - self-checking bench for wash_countdown
module tb_wash_countdown;

    localparam int TC = 4;
    localparam int SB = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       load  = 1'b0;
    logic [3:0] d1    = 4'd0;
    logic [3:0] d2    = 4'd0;
    logic [3:0] d3    = 4'd0;
    logic       sign  = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [7:0] light;
    logic [3:0] ena;
    logic       busy;
    logic       done;

    wash_countdown #(.TICK_CYCLES(TC), .SCAN_BITS(SB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .d1    (d1),
        .d2    (d2),
        .d3    (d3),
        .sign  (sign),
        .start (start),
        .pause (pause),
        .light (light),
        .ena   (ena),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: count held as a plain integer 0..999.
    localparam int M_IDLE = 0, M_LOADED = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;
    int m_st, m_cnt, m_sign, m_tick, m_scan;
    int seg_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    typedef struct {
        int ld, a, b, c, sg, st, ps;
        int eb, ed;
    } vec_t;
    vec_t tab [14];

    function automatic vec_t mk(int ld, int a, int b, int c, int sg, int st, int ps, int eb, int ed);
        vec_t v;
        v.ld = ld; v.a = a; v.b = b; v.c = c; v.sg = sg; v.st = st; v.ps = ps; v.eb = eb; v.ed = ed;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input int ld, input int a, input int b, input int c,
                          input int sg, input int st, input int ps);
        load  = ld[0];
        d1    = a[3:0];
        d2    = b[3:0];
        d3    = c[3:0];
        sign  = sg[0];
        start = st[0];
        pause = ps[0];
    endtask

    task automatic idle_in();
        set_in(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_cnt = 0; m_sign = 0; m_tick = 0; m_scan = 0;
    endtask

    task automatic model_step();
        int a, b, c;
        a = int'(d1); b = int'(d2); c = int'(d3);
        m_scan = (m_scan + 1) % (1 << SB);
        case (m_st)
            M_IDLE, M_LOADED, M_DONE: begin
                if (load && a <= 9 && b <= 9 && c <= 9) begin
                    m_cnt  = c * 100 + b * 10 + a;
                    m_sign = int'(sign);
                    m_st   = M_LOADED;
                end else if (m_st == M_LOADED && start) begin
                    m_tick = 0;
                    m_st   = (m_cnt == 0) ? M_DONE : M_RUN;
                end
            end
            M_RUN: begin
                if (pause) begin
                    m_st = M_PAUSE;
                end else if (m_tick == TC - 1) begin
                    m_tick = 0;
                    m_cnt  = m_cnt - 1;
                    if (m_cnt == 0) m_st = M_DONE;
                end else begin
                    m_tick = m_tick + 1;
                end
            end
            M_PAUSE: begin
                if (start && !pause) m_st = M_RUN;
            end
            default: m_st = M_IDLE;
        endcase
    endtask

    task automatic model_check();
        int sel, div, exp_light;
        sel = m_scan / (1 << (SB - 2));
        if (sel == 3) begin
            exp_light = m_sign ? 8'h40 : 8'h00;
        end else begin
            div = (sel == 0) ? 1 : (sel == 1) ? 10 : 100;
            exp_light = seg_tab[(m_cnt / div) % 10];
        end
        check("busy", int'(busy), (m_st == M_RUN || m_st == M_PAUSE) ? 1 : 0);
        check("done", int'(done), (m_st == M_DONE) ? 1 : 0);
        check("ena", int'(ena), 1 << sel);
        check("light", int'(light), exp_light);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        model_check();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ena", int'(ena), 4'b0001);
        check("rst_light", int'(light), 8'h3F);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int n, k;
        int exp_l [4] = '{8'h6D, 8'h07, 8'h3F, 8'h40};

        tab[0]  = mk(1, 10, 0, 0, 0, 0, 0, 0, 0);
        tab[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tab[2]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 1);
        tab[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tab[4]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 1);
        tab[5]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0);
        tab[6]  = mk(0, 0, 0, 0, 0, 1, 0, 1, 0);
        tab[7]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
        tab[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
        tab[9]  = mk(0, 0, 0, 0, 0, 1, 1, 1, 0);
        tab[10] = mk(1, 5, 5, 5, 0, 0, 0, 1, 0);
        tab[11] = mk(0, 0, 0, 0, 0, 1, 0, 1, 0);
        tab[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
        tab[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);

        model_reset();
        idle_in();
        do_reset();

        for (int i = 0; i < 14; i++) begin
            set_in(tab[i].ld, tab[i].a, tab[i].b, tab[i].c, tab[i].sg, tab[i].st, tab[i].ps);
            step();
            check($sformatf("tab%0d_busy", i), int'(busy), tab[i].eb);
            check($sformatf("tab%0d_done", i), int'(done), tab[i].ed);
        end
        idle_in();

        // 101 down to 000 with TICK_CYCLES=4 takes 404 RUN cycles.
        do_reset();
        set_in(1, 1, 0, 1, 0, 0, 0);
        step();
        set_in(0, 0, 0, 0, 0, 1, 0);
        step();
        idle_in();
        n = 0;
        while (!done && n < 1000) begin
            step();
            n++;
        end
        check("run_to_done", n, 404);

        // Pause at tick 2 for 10 cycles, then resume.
        do_reset();
        set_in(1, 0, 5, 0, 0, 0, 0);
        step();
        set_in(0, 0, 0, 0, 0, 1, 0);
        step();
        idle_in();
        step();
        step();
        set_in(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) step();
        check("pause_busy", int'(busy), 1);
        set_in(0, 0, 0, 0, 0, 1, 0);
        step();
        idle_in();
        for (int i = 0; i < 12; i++) step();

        // Scan sequence with sign set and count 075.
        do_reset();
        set_in(1, 5, 7, 0, 1, 0, 0);
        step();
        idle_in();
        k = 0;
        while (ena !== 4'b1000 && k < 40) begin
            step();
            k++;
        end
        while (ena !== 4'b0001 && k < 40) begin
            step();
            k++;
        end
        check("scan_sync", (k < 40) ? 1 : 0, 1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("scan%0d_ena", i), int'(ena), 1 << (i / 4));
            check($sformatf("scan%0d_light", i), int'(light), exp_l[i / 4]);
            step();
        end

        // Reset mid-RUN aborts; start alone afterwards does nothing.
        do_reset();
        set_in(1, 0, 5, 0, 0, 0, 0);
        step();
        set_in(0, 0, 0, 0, 0, 1, 0);
        step();
        idle_in();
        for (int i = 0; i < 6; i++) step();
        do_reset();
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        set_in(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step();
        check("abort_start_busy", int'(busy), 0);
        idle_in();

        // Randomised traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            set_in(($urandom_range(0, 9) == 0) ? 1 : 0,
                   ($urandom_range(0, 5) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9),
                   $urandom_range(0, 9),
                   ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : 0,
                   $urandom_range(0, 1),
                   ($urandom_range(0, 4) == 0) ? 1 : 0,
                   ($urandom_range(0, 7) == 0) ? 1 : 0);
            if ($urandom_range(0, 499) == 0) do_reset();
            else step();
        end
        idle_in();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wash_countdown.md
WASH_COUNTDOWN -- requirements
Module: wash_countdown

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 100000000, clk cycles per one-count decrement.
REQ-002 SHALL have parameter SCAN_BITS, default 16, width of the free-running scan divider; its top 2 bits select the digit.
REQ-003 clk input 1: single clock; all state changes on posedge clk.
REQ-004 rst_n input 1: reset, asynchronous and active-low.
REQ-005 load input 1: one-cycle request to capture the preset.
REQ-006 d1 input 4: preset ones digit, BCD.
REQ-007 d2 input 4: preset tens digit, BCD.
REQ-008 d3 input 4: preset hundreds digit, BCD.
REQ-009 sign input 1: preset sign flag, shown as '-' on digit 3.
REQ-010 start input 1: begin or resume the countdown.
REQ-011 pause input 1: suspend the countdown.
REQ-012 light output 8: segments; bit0=a ... bit6=g, bit7=dp; active-high.
REQ-013 ena output 4: one-hot digit enable; ena[0]=ones, ena[1]=tens, ena[2]=hundreds, ena[3]=sign.
REQ-014 busy output 1: high in RUN and PAUSE.
REQ-015 done output 1: high in DONE.

Function
REQ-016 SHALL implement states IDLE, LOADED, RUN, PAUSE and DONE.
REQ-017 IDLE/LOADED/DONE + load with all digits <=9: capture d1..d3 and sign into count registers next cycle, go to LOADED.
REQ-018 A load with any digit >9 SHALL be ignored; state and count stay unchanged.
REQ-019 load SHALL be ignored in RUN and PAUSE.
REQ-020 LOADED + start: go to RUN; tick counter cleared to 0.
REQ-021 LOADED + start with count 000: go directly to DONE next cycle, with no RUN cycle.
REQ-022 RUN: tick counter increments each cycle; at TICK_CYCLES-1 it wraps to 0 and count decrements by one.
REQ-023 Decrement SHALL be 3-digit BCD with borrow (e.g. 100 -> 099, 010 -> 009); digits never leave 0..9.
REQ-024 RUN, tick wrap while count = 001: count becomes 000 and state goes to DONE in the same cycle.
REQ-025 RUN + pause: go to PAUSE; the tick counter holds its value and is not cleared.
REQ-026 PAUSE + start with pause low: return to RUN and resume from the held tick value.
REQ-027 start and pause high together: pause wins (RUN -> PAUSE; PAUSE stays).
REQ-028 DONE SHALL hold until a valid load; start in DONE is ignored.
REQ-029 Scan divider SHALL free-run in every state, including during reset release, and never stop.
REQ-030 Scan select 0/1/2 SHALL drive ena 0001/0010/0100, with light = 7-seg code of ones/tens/hundreds.
REQ-031 Scan select 3 SHALL drive ena 1000, with light = 8'h40 ('-') if sign is set, else 8'h00.
REQ-032 7-seg codes (hex) SHALL be: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F; dp always 0.
REQ-033 light and ena SHALL be combinational from the scan select and count/sign registers, with no latch inferred.
REQ-034 The sign bit SHALL be display-only and SHALL NOT affect counting.

Reset
REQ-035 rst_n low SHALL immediately clear: state to IDLE, count to 000, sign to 0, tick and scan counters to 0.
REQ-036 Outputs during reset SHALL be busy=0, done=0, ena=0001, light=3F.
REQ-037 Reset asserted mid-RUN or mid-PAUSE SHALL abort the count; after release the block waits for a new load.

Verification
REQ-038 With TICK_CYCLES=4: load 1/0/1 (value 101), then start -> count 100 after 4 cycles, then 099; done after 404 cycles in RUN.
REQ-039 load d1=10 -> ignored: state IDLE, count 000. load 000 then start -> done=1 the next cycle, busy never high.
REQ-040 RUN with tick=2, assert pause for 10 cycles -> count frozen, busy=1. start -> decrement 2 cycles later.
REQ-041 start and pause asserted in the same cycle in RUN -> PAUSE. load during PAUSE -> ignored, count unchanged.
REQ-042 sign=1, count 075, SCAN_BITS=4: over 16 cycles ena sequences 0001/0010/0100/1000, with light 6D, 07, 3F, 40.
REQ-043 rst_n pulsed low for 1 cycle mid-RUN at count 050 -> IDLE, count 000, done=0. start alone afterwards -> no change.
